// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM program loader.
// The first byte of a word lands in the highest byte lane (big-endian).
package imem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DEPTH_DEF  = 64;

    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned FIRST_LANE = BYTE_LANES - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    function automatic logic is_loading(input state_t s);
        return (s == ST_COLLECT) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; word_full_o pulses
// combinationally on the accept of the fourth byte, the word is held until the next accept.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr_i) begin
            cnt_d   = 2'd0;
            shift_d = 32'd0;
        end else if (accept_i) begin
            cnt_d   = cnt_q + 2'd1;
            // Shifting left pushes earlier bytes toward the top lane.
            shift_d = {shift_q[8*FIRST_LANE-1:0], byte_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_o      = shift_q;
    assign word_full_o = accept_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: packs 4 bytes per word, writes one cycle after the 4th byte,
// holds the core in reset while loading; byte_ready drops during the write cycle and on abort.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              i_clk_w,
    input  logic              i_rst_w,
    input  logic              i_start_w,
    input  logic [ADDR_W:0]   i_len_w,
    input  logic              i_abort_w,
    input  logic              i_byte_valid_w,
    input  logic [7:0]        i_byte_w,
    output logic              o_byte_ready_w,
    output logic              o_we_w,
    output logic [ADDR_W-1:0] o_waddr_w,
    output logic [31:0]       o_wdata_w,
    output logic              o_cpu_rst_w,
    output logic              o_busy_w,
    output logic              o_done_w,
    output logic              o_err_w,
    output logic [ADDR_W:0]   o_words_w,
    output logic [31:0]       o_checksum_w
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         checksum_q, checksum_d;
    logic                cpu_rst_q;

    logic                start_phase;
    logic                len_ok;
    logic                start_ok;
    logic                byte_accept;
    logic                packer_clr;
    logic                word_full;
    logic [31:0]         packed_word;
    logic [ADDR_W:0]     words_inc;

    assign start_phase = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign len_ok      = (i_len_w != '0) && (i_len_w <= LEN_MAX);
    assign start_ok    = start_phase && i_start_w && len_ok;
    assign byte_accept = i_byte_valid_w && o_byte_ready_w;
    assign packer_clr  = start_ok || ((state_q == ST_COLLECT) && i_abort_w);
    assign words_inc   = words_q + (ADDR_W+1)'(1);

    word_packer u_packer (
        .clk_i       (i_clk_w),
        .rst_i       (i_rst_w),
        .clr_i       (packer_clr),
        .accept_i    (byte_accept),
        .byte_i      (i_byte_w),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start_w) begin
                    state_d = len_ok ? ST_COLLECT : ST_ERR;
                end
            end
            ST_COLLECT: begin
                if (i_abort_w) begin
                    state_d = ST_ERR;
                end else if (word_full) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The write itself always completes; abort only redirects what follows.
                if (i_abort_w) begin
                    state_d = ST_ERR;
                end else if (words_inc == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready_w = (state_q == ST_COLLECT) && !i_abort_w;
        o_we_w         = (state_q == ST_WRITE);
        o_busy_w       = is_loading(state_q);
        o_done_w       = (state_q == ST_DONE);
        o_err_w        = (state_q == ST_ERR);
    end

    always_comb begin
        len_d      = len_q;
        words_d    = words_q;
        waddr_d    = waddr_q;
        checksum_d = checksum_q;
        if (start_ok) begin
            len_d      = i_len_w;
            words_d    = '0;
            waddr_d    = '0;
            checksum_d = 32'd0;
        end else if (state_q == ST_WRITE) begin
            words_d    = words_inc;
            waddr_d    = waddr_q + ADDR_W'(1);
            checksum_d = checksum_q ^ packed_word;
        end
    end

    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            len_q      <= '0;
            words_q    <= '0;
            waddr_q    <= '0;
            checksum_q <= 32'd0;
            cpu_rst_q  <= 1'b1;
        end else begin
            len_q      <= len_d;
            words_q    <= words_d;
            waddr_q    <= waddr_d;
            checksum_q <= checksum_d;
            // Registered from the next state so the core reset tracks the state exactly.
            cpu_rst_q  <= is_loading(state_d);
        end
    end

    assign o_waddr_w    = waddr_q;
    assign o_wdata_w    = packed_word;
    assign o_words_w    = words_q;
    assign o_checksum_w = checksum_q;
    assign o_cpu_rst_w  = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, multi-word load, length errors,
// full-depth load, gaps/backpressure, abort and reset in the middle of a word.
module tb_imem_loader;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic          bvld = 1'b0;
    logic [7:0]    bdat = 8'h00;
    logic          rdy, we, cpu_rst, busy, done, err;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata, csum;
    logic [AW:0]   words;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int rst_low_busy = 0;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          acc_cyc[$];

    imem_loader #(.ADDR_W(AW), .DEPTH(64)) dut (
        .i_clk_w        (clk),
        .i_rst_w        (rst),
        .i_start_w      (start),
        .i_len_w        (len),
        .i_abort_w      (abort),
        .i_byte_valid_w (bvld),
        .i_byte_w       (bdat),
        .o_byte_ready_w (rdy),
        .o_we_w         (we),
        .o_waddr_w      (waddr),
        .o_wdata_w      (wdata),
        .o_cpu_rst_w    (cpu_rst),
        .o_busy_w       (busy),
        .o_done_w       (done),
        .o_err_w        (err),
        .o_words_w      (words),
        .o_checksum_w   (csum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (we) begin
            wr_addr.push_back(int'(waddr));
            wr_data.push_back(wdata);
            wr_cyc.push_back(cyc);
        end
        if (bvld && rdy) acc_cyc.push_back(cyc);
        if (rdy) rdy_cnt = rdy_cnt + 1;
        if (busy && !cpu_rst) rst_low_busy = rst_low_busy + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cyc=%0d want <10000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic start_load(input logic [AW:0] l);
        start = 1'b1; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Holds the byte until the loader takes it; returns at the negedge after acceptance.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        bvld = 1'b1; bdat = b;
        #1;
        while (!rdy && n < 20) begin
            @(negedge clk); #1; n++;
        end
        tests++;
        if (n >= 20) begin fails++; $display("FAIL push_byte_timeout: byte %h waited %0d cycles, required <20", b, n); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        tests++; if ({we, busy, done, err, rdy, waddr, wdata, words, csum} !== '0) begin fails++;
            $display("FAIL reset_outputs: we=%b busy=%b done=%b err=%b rdy=%b waddr=%h wdata=%h words=%0d csum=%h want all 0",
                     we, busy, done, err, rdy, waddr, wdata, words, csum); end
        rst = 1'b0;
        #1;
        tests++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL release_cpu_rst_hold: got %b want 1", cpu_rst); end
        @(negedge clk);
        tests++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL release_cpu_rst_drop: got %b want 0", cpu_rst); end
        tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL release_idle: busy/done/err=%b want 000", {busy, done, err}); end
    endtask

    task automatic test_two_word();
        logic [7:0] bs [8];
        bs = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C};
        clear_logs();
        rst_low_busy = 0;
        start_load(7'd2);
        tests++; if ({busy, cpu_rst, rdy} !== 3'b111) begin fails++; $display("FAIL two_collect: busy/cpu_rst/rdy=%b want 111", {busy, cpu_rst, rdy}); end
        for (int i = 0; i < 8; i++) push_byte(bs[i]);
        bvld = 1'b0;
        @(negedge clk);
        tests++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL two_wr_count: got %0d want 2", wr_addr.size()); end
        else begin
            tests++; if (wr_addr[0] !== 0 || wr_data[0] !== 32'h20080005) begin fails++; $display("FAIL two_wr0: got %h@%0d want 20080005@0", wr_data[0], wr_addr[0]); end
            tests++; if (wr_addr[1] !== 1 || wr_data[1] !== 32'h2009000C) begin fails++; $display("FAIL two_wr1: got %h@%0d want 2009000c@1", wr_data[1], wr_addr[1]); end
            tests++; if (wr_cyc[0] !== acc_cyc[3] + 1 || wr_cyc[1] !== acc_cyc[7] + 1) begin fails++;
                $display("FAIL two_we_latency: we at %0d,%0d want %0d,%0d", wr_cyc[0], wr_cyc[1], acc_cyc[3] + 1, acc_cyc[7] + 1); end
            tests++; if (acc_cyc[4] !== acc_cyc[3] + 2) begin fails++; $display("FAIL two_write_stall: byte4 accepted at %0d want %0d", acc_cyc[4], acc_cyc[3] + 2); end
        end
        tests++; if (words !== 7'd2 || csum !== 32'h00010009) begin fails++; $display("FAIL two_summary: words=%0d csum=%h want 2 00010009", words, csum); end
        tests++; if ({done, err, busy, cpu_rst} !== 4'b1000) begin fails++; $display("FAIL two_done: done/err/busy/cpu_rst=%b want 1000", {done, err, busy, cpu_rst}); end
        tests++; if (rst_low_busy !== 0) begin fails++; $display("FAIL two_cpu_rst_in_load: low for %0d cycles want 0", rst_low_busy); end
    endtask

    task automatic test_len_err();
        logic [AW:0] bad [2];
        int r0;
        bad = '{7'd0, 7'd65};
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            r0 = rdy_cnt;
            start_load(bad[k]);
            tests++; if ({err, done, busy, rdy, cpu_rst} !== 5'b10000) begin fails++;
                $display("FAIL len_err_%0d: err/done/busy/rdy/cpu_rst=%b want 10000", bad[k], {err, done, busy, rdy, cpu_rst}); end
            repeat (2) @(negedge clk);
            tests++; if (wr_addr.size() !== 0 || rdy_cnt !== r0 || err !== 1'b1) begin fails++;
                $display("FAIL len_err_quiet_%0d: writes=%0d ready_cycles=%0d err=%b want 0 0 1", bad[k], wr_addr.size(), rdy_cnt - r0, err); end
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] exp_w;
        logic [31:0] exp_sum;
        int          bad_cnt;
        clear_logs();
        exp_sum = 32'd0;
        bad_cnt = 0;
        start_load(7'd64);
        for (int i = 0; i < 256; i++) push_byte(8'(i));
        bvld = 1'b0;
        @(negedge clk);
        tests++; if (wr_addr.size() !== 64) begin fails++; $display("FAIL depth_wr_count: got %0d want 64", wr_addr.size()); end
        else begin
            for (int w = 0; w < 64; w++) begin
                exp_w = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
                exp_sum = exp_sum ^ exp_w;
                if (wr_addr[w] !== w || wr_data[w] !== exp_w) bad_cnt++;
            end
            tests++; if (bad_cnt !== 0) begin fails++; $display("FAIL depth_wr_data: %0d bad words want 0", bad_cnt); end
            tests++; if (words !== 7'd64 || csum !== exp_sum || done !== 1'b1) begin fails++;
                $display("FAIL depth_summary: words=%0d csum=%h done=%b want 64 %h 1", words, csum, done, exp_sum); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bs [4];
        bs = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_logs();
        start_load(7'd1);
        for (int i = 0; i < 4; i++) begin
            push_byte(bs[i]);
            bvld = 1'b0;
            @(negedge clk);
        end
        tests++; if (acc_cyc.size() !== 4) begin fails++; $display("FAIL bp_accept_count: got %0d want 4", acc_cyc.size()); end
        else begin
            tests++; if (acc_cyc[1] !== acc_cyc[0] + 2 || acc_cyc[3] !== acc_cyc[2] + 2) begin fails++;
                $display("FAIL bp_gap_accept: deltas %0d %0d want 2 2", acc_cyc[1] - acc_cyc[0], acc_cyc[3] - acc_cyc[2]); end
        end
        tests++; if (wr_addr.size() !== 1 || wr_data[0] !== 32'hDEADBEEF || wr_addr[0] !== 0) begin fails++;
            $display("FAIL bp_write: count=%0d data=%h want 1 deadbeef@0", wr_addr.size(), wr_data[0]); end
        tests++; if (done !== 1'b1 || words !== 7'd1) begin fails++; $display("FAIL bp_done: done=%b words=%0d want 1 1", done, words); end
    endtask

    task automatic test_abort();
        logic [7:0] bs [4];
        bs = '{8'h00, 8'h00, 8'h00, 8'h0C};
        clear_logs();
        start_load(7'd1);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        bvld = 1'b1; bdat = 8'h44; abort = 1'b1;
        #1;
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b want 0", rdy); end
        @(negedge clk);
        abort = 1'b0; bvld = 1'b0;
        tests++; if (acc_cyc.size() !== 3 || wr_addr.size() !== 0) begin fails++;
            $display("FAIL abort_no_accept: accepts=%0d writes=%0d want 3 0", acc_cyc.size(), wr_addr.size()); end
        tests++; if ({err, busy, cpu_rst} !== 3'b100) begin fails++; $display("FAIL abort_err: err/busy/cpu_rst=%b want 100", {err, busy, cpu_rst}); end
        clear_logs();
        start_load(7'd1);
        for (int i = 0; i < 4; i++) push_byte(bs[i]);
        bvld = 1'b0;
        @(negedge clk);
        tests++; if (wr_addr.size() !== 1 || wr_data[0] !== 32'h0000000C || wr_addr[0] !== 0) begin fails++;
            $display("FAIL abort_reload: count=%0d data=%h want 1 0000000c@0", wr_addr.size(), wr_data[0]); end
        tests++; if ({done, err} !== 2'b10 || csum !== 32'h0000000C) begin fails++; $display("FAIL abort_reload_done: done/err=%b csum=%h want 10 0000000c", {done, err}, csum); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bs [6];
        bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02};
        clear_logs();
        start_load(7'd2);
        for (int i = 0; i < 6; i++) push_byte(bs[i]);
        bvld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (wr_addr.size() !== 1 || wr_data[0] !== 32'hAABBCCDD) begin fails++;
            $display("FAIL rstmid_writes: count=%0d first=%h want 1 aabbccdd", wr_addr.size(), wr_data[0]); end
        tests++; if ({busy, done, err, cpu_rst} !== 4'b0001 || words !== '0 || csum !== '0) begin fails++;
            $display("FAIL rstmid_state: busy/done/err/cpu_rst=%b words=%0d csum=%h want 0001 0 0", {busy, done, err, cpu_rst}, words, csum); end
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        start_load(7'd1);
        push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
        bvld = 1'b0;
        @(negedge clk);
        tests++; if (wr_addr.size() !== 1 || wr_addr[0] !== 0 || wr_data[0] !== 32'h55667788) begin fails++;
            $display("FAIL rstmid_reload: count=%0d data=%h@%0d want 1 55667788@0", wr_addr.size(), wr_data[0], wr_addr[0]); end
        tests++; if (words !== 7'd1 || done !== 1'b1) begin fails++; $display("FAIL rstmid_words: words=%0d done=%b want 1 1", words, done); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_two_word();
        test_len_err();
        test_full_depth();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
